// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types, colour defaults and width helper for the sprite layer mapper.
package sprite_pkg;

  typedef logic [23:0] rgb24_t;

  // Per-sprite attribute record held in shadow and active banks
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
    logic       flip;
  } sprite_attr_t;

  localparam rgb24_t KEY_COLOR_DEFAULT = 24'hEE35FF;
  localparam rgb24_t SKY_COLOR_DEFAULT = 24'h5C94FC;

  // Address width for a table of 'depth' entries, never below one bit
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// sprite_hit_unit: per-sprite screen-relative offset, hit test and sprite ROM address.
module sprite_hit_unit
  import sprite_pkg::*;
#(
  parameter  int unsigned SPRITE_W = 16,
  parameter  int unsigned SPRITE_H = 16,
  localparam int unsigned CW       = addr_width(SPRITE_W),
  localparam int unsigned RW       = addr_width(SPRITE_H),
  localparam int unsigned AW       = addr_width(SPRITE_W * SPRITE_H)
) (
  input  logic [9:0]    draw_x,
  input  logic [9:0]    draw_y,
  input  sprite_attr_t  attr,
  output logic          hit_c,
  output logic [AW-1:0] addr_c
);

  logic [9:0]    dx;
  logic [9:0]    dy;
  logic [CW-1:0] col;

  // Wrapping 10-bit offsets; mirrored column is the bitwise inverse for power-of-two widths
  always_comb begin
    dx     = draw_x - attr.x;
    dy     = draw_y - attr.y;
    hit_c  = attr.en && ({1'b0, dx} < 11'(SPRITE_W)) && ({1'b0, dy} < 11'(SPRITE_H));
    col    = attr.flip ? ~dx[CW-1:0] : dx[CW-1:0];
    addr_c = AW'({dy[RW-1:0], col});
  end

endmodule

// File: rtl/sprite_layer_mapper.sv
// sprite_layer_mapper: composites keyed sprites over a scrolled tile ground and flat sky.
// Define SPRITE_HFLIP_EN to store attr_flip and mirror sprite columns.
module sprite_layer_mapper
  import sprite_pkg::*;
#(
  parameter  int unsigned NUM_SPRITES = 4,
  parameter  int unsigned SPRITE_W    = 16,
  parameter  int unsigned SPRITE_H    = 16,
  parameter  int unsigned TILE_SIZE   = 16,
  parameter  int unsigned GROUND_Y    = 416,
  parameter  rgb24_t      KEY_COLOR   = KEY_COLOR_DEFAULT,
  parameter  rgb24_t      SKY_COLOR   = SKY_COLOR_DEFAULT,
  parameter  int unsigned ROM_LATENCY = 1,
  localparam int unsigned IW          = addr_width(NUM_SPRITES),
  localparam int unsigned SAW         = addr_width(SPRITE_W * SPRITE_H),
  localparam int unsigned TAW         = addr_width(TILE_SIZE * TILE_SIZE)
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic                                pixel_ce,
  input  logic [9:0]                          DrawX,
  input  logic [9:0]                          DrawY,
  input  logic                                blank,
  input  logic [9:0]                          scroll_x,
  input  logic                                attr_valid,
  output logic                                attr_ready,
  input  logic [IW-1:0]                       attr_idx,
  input  logic [9:0]                          attr_x,
  input  logic [9:0]                          attr_y,
  input  logic                                attr_en,
  input  logic                                attr_flip,
  output logic [NUM_SPRITES-1:0][SAW-1:0]     spr_addr,
  input  logic [NUM_SPRITES-1:0][23:0]        spr_data,
  output logic [TAW-1:0]                      tile_addr,
  input  logic [23:0]                         tile_data,
  output logic [7:0]                          Red,
  output logic [7:0]                          Green,
  output logic [7:0]                          Blue
);

  localparam int unsigned TB = addr_width(TILE_SIZE);
  localparam int unsigned L  = ROM_LATENCY;

  sprite_attr_t           shadow [NUM_SPRITES];
  sprite_attr_t           active [NUM_SPRITES];
  logic [9:0]             scroll_q;
  logic                   commit_c;
  logic                   flip_in;
  logic [9:0]             gx_c;
  logic [NUM_SPRITES-1:0] hit_c;
  logic [SAW-1:0]         addr_c [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hit_d  [L+1];
  logic [L:0]             ground_d;
  logic [L:0]             blank_d;
  rgb24_t                 pix_c;
  rgb24_t                 rgb_q;

`ifdef SPRITE_HFLIP_EN
  assign flip_in = attr_flip;
`else
  logic unused_flip;
  assign unused_flip = attr_flip;
  assign flip_in     = 1'b0;
`endif

  // Frame start: shadow bank becomes active, attribute port stalls for this cycle
  assign commit_c   = pixel_ce && (DrawX == 10'd0) && (DrawY == 10'd0);
  assign attr_ready = Reset || !commit_c;
  assign gx_c       = DrawX + scroll_q;

  // Shadow writes and atomic commit to the active bank
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      scroll_q <= '0;
    end else if (commit_c) begin
      active   <= shadow;
      scroll_q <= scroll_x;
    end else if (attr_valid) begin
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        if (attr_idx == IW'(i)) begin
          shadow[i] <= '{x: attr_x, y: attr_y, en: attr_en, flip: flip_in};
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_SPRITES); g++) begin : g_hit
    sprite_hit_unit #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H)
    ) u_hit (
      .draw_x (DrawX),
      .draw_y (DrawY),
      .attr   (active[g]),
      .hit_c  (hit_c[g]),
      .addr_c (addr_c[g])
    );
  end

  // Stage 0 address/flag register and flag delay line matching ROM latency
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k <= int'(L); k++) hit_d[k] <= '0;
      ground_d  <= '0;
      blank_d   <= '0;
      spr_addr  <= '0;
      tile_addr <= '0;
    end else if (pixel_ce) begin
      hit_d[0]  <= hit_c;
      ground_d  <= {ground_d[L-1:0], (DrawY >= 10'(GROUND_Y))};
      blank_d   <= {blank_d[L-1:0], blank};
      for (int i = 0; i < int'(NUM_SPRITES); i++) spr_addr[i] <= addr_c[i];
      tile_addr <= TAW'({DrawY[TB-1:0], gx_c[TB-1:0]});
      for (int k = 1; k <= int'(L); k++) hit_d[k] <= hit_d[k-1];
    end
  end

  // Priority compose: lowest opaque sprite, then ground, then sky; blanking forces black
  always_comb begin
    pix_c = SKY_COLOR;
    if (ground_d[L]) pix_c = tile_data;
    for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
      if (hit_d[L][i] && (spr_data[i] != KEY_COLOR)) pix_c = spr_data[i];
    end
    if (!blank_d[L]) pix_c = '0;
  end

  // Output colour register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rgb_q <= '0;
    end else if (pixel_ce) begin
      rgb_q <= pix_c;
    end
  end

  assign Red   = rgb_q[23:16];
  assign Green = rgb_q[15:8];
  assign Blue  = rgb_q[7:0];

endmodule

// File: tb/tb_sprite_layer_mapper.sv
// tb_sprite_layer_mapper: scoreboard bench with behavioural sprite/tile ROMs and a reference compositor.
module tb_sprite_layer_mapper;

  localparam int          NS   = 4;
  localparam int          L    = 1;
  localparam logic [23:0] KEY  = 24'hEE35FF;
  localparam logic [23:0] SKY  = 24'h5C94FC;

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 pixel_ce;
  logic [9:0]           DrawX, DrawY;
  logic                 blank;
  logic [9:0]           scroll_x;
  logic                 attr_valid;
  logic                 attr_ready;
  logic [1:0]           attr_idx;
  logic [9:0]           attr_x, attr_y;
  logic                 attr_en, attr_flip;
  logic [NS-1:0][7:0]   spr_addr;
  logic [NS-1:0][23:0]  spr_data;
  logic [7:0]           tile_addr;
  logic [23:0]          tile_data;
  logic [7:0]           Red, Green, Blue;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [23:0] rgb;
    logic [9:0]  x;
    logic [9:0]  y;
  } exp_t;
  exp_t sb_q[$];

  // ROM contents and reference model state
  logic [23:0] spr_val [NS];
  logic [NS-1:0] key_sel;
  logic [9:0] s_x [NS], s_y [NS];
  logic       s_en[NS], s_fl[NS];
  logic [9:0] a_x [NS], a_y [NS];
  logic       a_en[NS], a_fl[NS];
  logic [9:0] a_scroll;

  logic [23:0] spr_pipe [NS][L];
  logic [23:0] tile_pipe [L];

  sprite_layer_mapper #(
    .NUM_SPRITES (NS),
    .ROM_LATENCY (L)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .pixel_ce   (pixel_ce),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .scroll_x   (scroll_x),
    .attr_valid (attr_valid),
    .attr_ready (attr_ready),
    .attr_idx   (attr_idx),
    .attr_x     (attr_x),
    .attr_y     (attr_y),
    .attr_en    (attr_en),
    .attr_flip  (attr_flip),
    .spr_addr   (spr_addr),
    .spr_data   (spr_data),
    .tile_addr  (tile_addr),
    .tile_data  (tile_data),
    .Red        (Red),
    .Green      (Green),
    .Blue       (Blue)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] spr_word(input int i, input logic [7:0] a);
    if (key_sel[i]) return KEY;
    return spr_val[i] ^ {16'h0, a};
  endfunction

  function automatic logic [23:0] tile_word(input logic [7:0] a);
    return {8'h40, a, 8'h0F};
  endfunction

  // Synchronous ROMs advancing on pixel_ce
  always @(posedge Clk) begin
    if (pixel_ce) begin
      for (int i = 0; i < NS; i++) begin
        spr_pipe[i][0] <= spr_word(i, spr_addr[i]);
        for (int k = 1; k < L; k++) spr_pipe[i][k] <= spr_pipe[i][k-1];
      end
      tile_pipe[0] <= tile_word(tile_addr);
      for (int k = 1; k < L; k++) tile_pipe[k] <= tile_pipe[k-1];
    end
  end

  always_comb begin
    for (int i = 0; i < NS; i++) spr_data[i] = spr_pipe[i][L-1];
    tile_data = tile_pipe[L-1];
  end

  function automatic logic [23:0] model_pixel(input logic [9:0] x, input logic [9:0] y, input logic b);
    logic [9:0]  dx, dy, col, gx;
    logic [23:0] w;
    if (!b) return 24'h0;
    for (int i = 0; i < NS; i++) begin
      if (a_en[i]) begin
        dx = x - a_x[i];
        dy = y - a_y[i];
        if (dx < 10'd16 && dy < 10'd16) begin
          col = dx;
`ifdef SPRITE_HFLIP_EN
          if (a_fl[i]) col = 10'd15 - dx;
`endif
          w = spr_word(i, 8'(dy * 10'd16 + col));
          if (w != KEY) return w;
        end
      end
    end
    if (y >= 10'd416) begin
      gx = x + a_scroll;
      return tile_word(8'((gx % 10'd16) + (y % 10'd16) * 10'd16));
    end
    return SKY;
  endfunction

  task automatic begin_beat(input logic [9:0] x, input logic [9:0] y, input logic b);
    exp_t e;
    @(negedge Clk);
    DrawX = x; DrawY = y; blank = b; pixel_ce = 1'b1;
    e.rgb = model_pixel(x, y, b); e.x = x; e.y = y;
    sb_q.push_back(e);
    if (x == 10'd0 && y == 10'd0) begin
      for (int i = 0; i < NS; i++) begin
        a_x[i] = s_x[i]; a_y[i] = s_y[i]; a_en[i] = s_en[i]; a_fl[i] = s_fl[i];
      end
      a_scroll = scroll_x;
    end
  endtask

  task automatic end_beat();
    exp_t e;
    @(posedge Clk); #1;
    if (sb_q.size() == L + 2) begin
      e = sb_q.pop_front();
      n_checks++;
      if ({Red, Green, Blue} !== e.rgb) begin
        n_fail++;
        $display("FAIL pixel(%0d,%0d): rgb=%06h expected %06h", e.x, e.y, {Red, Green, Blue}, e.rgb);
      end
    end
  endtask

  task automatic beat(input logic [9:0] x, input logic [9:0] y, input logic b);
    begin_beat(x, y, b);
    end_beat();
  endtask

  task automatic drain();
    repeat (L + 1) beat(10'd1, 10'd1, 1'b0);
  endtask

  task automatic commit();
    beat(10'd0, 10'd0, 1'b0);
  endtask

  task automatic do_reset();
    exp_t z;
    @(negedge Clk);
    Reset = 1'b1; pixel_ce = 1'b0; attr_valid = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int i = 0; i < NS; i++) begin
      s_x[i] = '0; s_y[i] = '0; s_en[i] = 1'b0; s_fl[i] = 1'b0;
      a_x[i] = '0; a_y[i] = '0; a_en[i] = 1'b0; a_fl[i] = 1'b0;
    end
    a_scroll = '0;
    sb_q.delete();
    z.rgb = 24'h0; z.x = '0; z.y = '0;
    repeat (L + 1) sb_q.push_back(z);
  endtask

  task automatic write_attr(input int idx, input logic [9:0] x, input logic [9:0] y,
                            input logic en, input logic fl);
    @(negedge Clk);
    pixel_ce = 1'b0;
    attr_valid = 1'b1; attr_idx = 2'(idx); attr_x = x; attr_y = y; attr_en = en; attr_flip = fl;
    #1;
    n_checks++;
    if (attr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL attr_ready idle: got %b expected 1", attr_ready);
    end
    @(posedge Clk); #1;
    attr_valid = 1'b0;
    s_x[idx] = x; s_y[idx] = y; s_en[idx] = en; s_fl[idx] = fl;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({Red, Green, Blue} !== 24'h0 || attr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: rgb=%06h ready=%b expected 000000 1", {Red, Green, Blue}, attr_ready);
    end
  endtask

  task automatic test_background();
    beat(10'd50, 10'd100, 1'b1);
    beat(10'd20, 10'd420, 1'b1);
    beat(10'd5,  10'd430, 1'b1);
    beat(10'd639, 10'd415, 1'b1);
    beat(10'd639, 10'd479, 1'b1);
    drain();
  endtask

  task automatic test_single_sprite();
    write_attr(0, 10'd100, 10'd200, 1'b1, 1'b0);
    commit();
    begin_beat(10'd105, 10'd203, 1'b1);
    end_beat();
    n_checks++;
    if (spr_addr[0] !== 8'd53) begin
      n_fail++;
      $display("FAIL spr_addr0: got %0d expected 53", spr_addr[0]);
    end
    beat(10'd99,  10'd203, 1'b1);
    beat(10'd115, 10'd215, 1'b1);
    beat(10'd116, 10'd203, 1'b1);
    beat(10'd100, 10'd199, 1'b1);
    beat(10'd100, 10'd216, 1'b1);
    drain();
  endtask

  task automatic test_priority();
    key_sel[0] = 1'b1;
    write_attr(1, 10'd108, 10'd200, 1'b1, 1'b0);
    commit();
    beat(10'd110, 10'd205, 1'b1);
    beat(10'd104, 10'd205, 1'b1);
    beat(10'd120, 10'd205, 1'b1);
    drain();
    key_sel[0] = 1'b0;
    spr_val[0] = 24'hABCDEF;
    beat(10'd110, 10'd205, 1'b1);
    beat(10'd120, 10'd210, 1'b1);
    drain();
  endtask

  task automatic test_flip();
    write_attr(2, 10'd300, 10'd50, 1'b1, 1'b1);
    commit();
    begin_beat(10'd300, 10'd52, 1'b1);
    end_beat();
    n_checks++;
`ifdef SPRITE_HFLIP_EN
    if (spr_addr[2] !== 8'd47) begin
      n_fail++;
      $display("FAIL flip addr: got %0d expected 47", spr_addr[2]);
    end
`else
    if (spr_addr[2] !== 8'd32) begin
      n_fail++;
      $display("FAIL flip addr: got %0d expected 32", spr_addr[2]);
    end
`endif
    beat(10'd315, 10'd52, 1'b1);
    drain();
  endtask

  task automatic test_commit_write();
    begin_beat(10'd0, 10'd0, 1'b0);
    attr_valid = 1'b1; attr_idx = 2'd3; attr_x = 10'd400; attr_y = 10'd300;
    attr_en = 1'b1; attr_flip = 1'b0;
    #1;
    n_checks++;
    if (attr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL commit stall: attr_ready=%b expected 0", attr_ready);
    end
    end_beat();
    begin_beat(10'd1, 10'd0, 1'b0);
    #1;
    n_checks++;
    if (attr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post-commit ready: attr_ready=%b expected 1", attr_ready);
    end
    end_beat();
    attr_valid = 1'b0;
    s_x[3] = 10'd400; s_y[3] = 10'd300; s_en[3] = 1'b1; s_fl[3] = 1'b0;
    beat(10'd405, 10'd305, 1'b1);
    drain();
    commit();
    beat(10'd405, 10'd305, 1'b1);
    beat(10'd415, 10'd315, 1'b1);
    drain();
  endtask

  task automatic test_scroll();
    scroll_x = 10'd5;
    commit();
    scroll_x = 10'd9;
    begin_beat(10'd12, 10'd416, 1'b1);
    end_beat();
    n_checks++;
    if (tile_addr !== 8'd1) begin
      n_fail++;
      $display("FAIL tile_addr scroll: got %0d expected 1", tile_addr);
    end
    beat(10'd12, 10'd417, 1'b1);
    beat(10'd27, 10'd470, 1'b1);
    beat(10'd200, 10'd450, 1'b0);
    drain();
  endtask

  task automatic test_hold();
    logic [23:0] rgb_s;
    logic [7:0]  addr_s;
    beat(10'd405, 10'd305, 1'b1);
    beat(10'd406, 10'd306, 1'b1);
    beat(10'd60, 10'd440, 1'b1);
    rgb_s  = {Red, Green, Blue};
    addr_s = spr_addr[3];
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      pixel_ce = 1'b0;
      DrawX = 10'(c * 37 + 3); DrawY = 10'(c * 11 + 7); blank = c[0];
      @(posedge Clk); #1;
      n_checks++;
      if ({Red, Green, Blue} !== rgb_s || spr_addr[3] !== addr_s) begin
        n_fail++;
        $display("FAIL hold c=%0d: rgb=%06h addr=%0d expected %06h %0d",
                 c, {Red, Green, Blue}, spr_addr[3], rgb_s, addr_s);
      end
    end
    beat(10'd410, 10'd310, 1'b1);
    drain();
  endtask

  task automatic test_reset_midframe();
    beat(10'd405, 10'd305, 1'b1);
    beat(10'd105, 10'd203, 1'b1);
    do_reset();
    beat(10'd405, 10'd305, 1'b1);
    beat(10'd105, 10'd203, 1'b1);
    beat(10'd30, 10'd440, 1'b1);
    drain();
    commit();
    beat(10'd405, 10'd305, 1'b1);
    write_attr(3, 10'd400, 10'd300, 1'b1, 1'b0);
    commit();
    beat(10'd405, 10'd305, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    write_attr(0, 10'd390, 10'd290, 1'b1, 1'b1);
    write_attr(1, 10'd398, 10'd296, 1'b1, 1'b0);
    write_attr(2, 10'd385, 10'd405, 1'b1, 1'b0);
    scroll_x = 10'd1021;
    commit();
    for (int n = 0; n < 60; n++) begin
      logic [9:0] x, y;
      x = 10'(380 + $urandom_range(0, 40));
      y = (n % 2 == 0) ? 10'(280 + $urandom_range(0, 40)) : 10'(400 + $urandom_range(0, 30));
      beat(x, y, ($urandom_range(0, 7) != 0));
    end
    drain();
  endtask

  initial begin
    Reset = 1'b0; pixel_ce = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0; scroll_x = '0;
    attr_valid = 1'b0; attr_idx = '0; attr_x = '0; attr_y = '0; attr_en = 1'b0; attr_flip = 1'b0;
    spr_val[0] = 24'h00A0B0;
    spr_val[1] = 24'h123456;
    spr_val[2] = 24'h3C5A70;
    spr_val[3] = 24'h80FF20;
    key_sel = '0;
    repeat (2) @(posedge Clk);
    test_reset();
    test_background();
    test_single_sprite();
    test_priority();
    test_flip();
    test_commit_write();
    test_scroll();
    test_hold();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
